// File: rtl/seg_display_ctrl_if.sv
// CPU IO bus toward the seven-segment display controller.
// Latency: none (wires only).
// Backpressure: none; the bus is strobe-based with no stall.
interface seg_display_ctrl_if;
    logic        seg_ctrl;
    logic        io_write;
    logic        io_read;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    // CPU side drives strobes and data, receives readback
    modport master (
        output seg_ctrl, io_write, io_read, addr, wdata,
        input  rdata
    );

    // Display controller side
    modport slave (
        input  seg_ctrl, io_write, io_read, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// Multiplexed 8-digit seven-segment display with CPU-visible DATA/CTRL registers.
// Latency: register writes reach seg_an/seg_out one cycle after the write edge; rdata one cycle after the read edge.
// Backpressure: none; every access completes on the edge it is presented.
module seg_display_ctrl #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_display_ctrl_if.slave     bus,
    output logic [7:0]            seg_an,
    output logic [7:0]            seg_out
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      data_q,    data_d;
    logic [7:0]       ctrl_en_q, ctrl_en_d;
    logic [7:0]       dp_q,      dp_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       idx_q,     idx_d;
    logic [31:0]      rdata_q,   rdata_d;
    logic [7:0]       seg_an_q,  seg_an_d;
    logic [7:0]       seg_out_q, seg_out_d;

    logic             wr_en;
    logic             rd_en;
    logic             wrap;
    logic [3:0]       nib;
    logic             dig_en;

    // Only addr[2] selects a register; the remaining bits are don't-care.
    logic unused_addr;
    assign unused_addr = ^{bus.addr[3], bus.addr[1:0]};

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    // Register file: write updates, readback returns the pre-write value
    always_comb begin
        wr_en     = bus.seg_ctrl & bus.io_write;
        rd_en     = bus.seg_ctrl & bus.io_read;
        data_d    = data_q;
        ctrl_en_d = ctrl_en_q;
        dp_d      = dp_q;
        rdata_d   = 32'h0;
        if (wr_en) begin
            if (bus.addr[2]) begin
                ctrl_en_d = bus.wdata[7:0];
                dp_d      = bus.wdata[15:8];
            end else begin
                data_d    = bus.wdata;
            end
        end
        if (rd_en) begin
            rdata_d = bus.addr[2] ? {16'h0, dp_q, ctrl_en_q} : data_q;
        end
    end

    // Scan prescaler and digit index
    always_comb begin
        wrap      = (div_cnt_q == CNT_MAX);
        div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
        idx_d     = wrap ? idx_q + 3'd1 : idx_q;
    end

    // Display drive, computed from the post-update index and registers so writes show next cycle
    always_comb begin
        nib       = data_d[{idx_d, 2'b00} +: 4];
        dig_en    = ctrl_en_d[idx_d];
        seg_an_d  = 8'hFF;
        seg_out_d = 8'hFF;
        if (dig_en) begin
            seg_an_d  = ~(8'h01 << idx_d);
            seg_out_d = {~dp_d[idx_d], seg_decode(nib)};
        end
    end

    // State registers with synchronous reset; reset discards any concurrent access
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= 32'h0;
            ctrl_en_q <= 8'hFF;
            dp_q      <= 8'h00;
            div_cnt_q <= '0;
            idx_q     <= 3'd0;
            rdata_q   <= 32'h0;
            seg_an_q  <= 8'hFF;
            seg_out_q <= 8'hFF;
        end else begin
            data_q    <= data_d;
            ctrl_en_q <= ctrl_en_d;
            dp_q      <= dp_d;
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            rdata_q   <= rdata_d;
            seg_an_q  <= seg_an_d;
            seg_out_q <= seg_out_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign seg_an    = seg_an_q;
    assign seg_out   = seg_out_q;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with SCAN_DIV=4.
// Latency: expectations assume outputs settle one cycle after each edge.
// Backpressure: not applicable.
module tb_seg_display_ctrl;
    logic       clk;
    logic       rst;
    logic [7:0] seg_an;
    logic [7:0] seg_out;
    int         n_cmp;
    int         n_fail;
    int         cyc;

    seg_display_ctrl_if bus ();

    seg_display_ctrl #(.SCAN_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .seg_an  (seg_an),
        .seg_out (seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected patterns for DATA=89ABCDEF, digits 0..7
    logic [7:0] hex_tbl [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};

    // Model: cyc = edges since the last reset edge; div_cnt = cyc%4, idx = (cyc/4)%8
    task automatic tick();
        @(posedge clk);
        if (rst) cyc = 0;
        else     cyc++;
        #1;
    endtask

    function automatic int exp_idx();
        return (cyc / 4) % 8;
    endfunction

    function automatic logic [7:0] an_of(input int i);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << i);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_idx(input int i);
        for (int n = 0; n < 40 && exp_idx() != i; n++) tick();
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.seg_ctrl = 1'b1; bus.io_write = 1'b1; bus.addr = a; bus.wdata = d;
        tick();
        bus.seg_ctrl = 1'b0; bus.io_write = 1'b0; bus.wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [3:0] a);
        bus.seg_ctrl = 1'b1; bus.io_read = 1'b1; bus.addr = a;
        tick();
        bus.seg_ctrl = 1'b0; bus.io_read = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0;
        bus.seg_ctrl = 1'b0; bus.io_write = 1'b0; bus.io_read = 1'b0;
        bus.addr = 4'h0; bus.wdata = 32'h0;
        rst = 1'b1;
        tick(); tick();
        check("rst_an",    {24'h0, seg_an},  32'hFF);
        check("rst_seg",   {24'h0, seg_out}, 32'hFF);
        check("rst_rdata", bus.rdata,        32'h0);

        // Reset release and scan: digit 0 for cycles 1..3, then each digit for 4 cycles, wrapping
        rst = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            tick();
            check("scan_an",  {24'h0, seg_an},  {24'h0, an_of(exp_idx())});
            check("scan_seg", {24'h0, seg_out}, 32'hC0);
            check("scan_onehot", $countones(~seg_an) <= 1, 1);
        end

        // Hex decode of all nibbles
        bus_write(4'h0, 32'h89AB_CDEF);
        for (int i = 0; i < 8; i++) begin
            wait_idx(i);
            check("hex_an",  {24'h0, seg_an},  {24'h0, an_of(i)});
            check("hex_seg", {24'h0, seg_out}, {24'h0, hex_tbl[i]});
        end

        // Digit mask and dp mask; upper CTRL bits discarded
        bus_write(4'h4, 32'h0001_0105);
        for (int i = 0; i < 8; i++) begin
            wait_idx(i);
            check("mask_an",  {24'h0, seg_an},
                  (i == 0 || i == 2) ? {24'h0, an_of(i)} : 32'hFF);
            check("mask_seg", {24'h0, seg_out},
                  (i == 0) ? 32'h0E : (i == 2) ? 32'hA1 : 32'hFF);
        end
        bus_read(4'h4);
        check("rd_ctrl", bus.rdata, 32'h0000_0105);
        tick();
        check("rd_idle", bus.rdata, 32'h0);

        // Chip select gating; addr bits other than [2] ignored
        bus_write(4'h4, 32'h0000_00FF);
        bus.seg_ctrl = 1'b0; bus.io_write = 1'b1; bus.addr = 4'h0; bus.wdata = 32'h1234_5678;
        tick();
        bus.io_write = 1'b0;
        bus_read(4'hB);
        check("rd_data_nocs_wr", bus.rdata, 32'h89AB_CDEF);
        bus.seg_ctrl = 1'b0; bus.io_read = 1'b1; bus.addr = 4'h0;
        tick();
        bus.io_read = 1'b0;
        check("rd_nocs", bus.rdata, 32'h0);

        // Simultaneous read+write returns the old value
        bus_write(4'h0, 32'h1111_1111);
        bus.seg_ctrl = 1'b1; bus.io_read = 1'b1; bus.io_write = 1'b1;
        bus.addr = 4'h0; bus.wdata = 32'h2222_2222;
        tick();
        bus.seg_ctrl = 1'b0; bus.io_read = 1'b0; bus.io_write = 1'b0;
        check("rw_old", bus.rdata, 32'h1111_1111);
        bus_read(4'h0);
        check("rw_new", bus.rdata, 32'h2222_2222);

        // Reset mid-scan at digit 5 with a concurrent write and read
        wait_idx(5);
        check("pre_rst_an",  {24'h0, seg_an},  32'hDF);
        check("pre_rst_seg", {24'h0, seg_out}, 32'hA4);
        rst = 1'b1;
        bus.seg_ctrl = 1'b1; bus.io_write = 1'b1; bus.io_read = 1'b1;
        bus.addr = 4'h0; bus.wdata = 32'h3333_3333;
        tick();
        bus.seg_ctrl = 1'b0; bus.io_write = 1'b0; bus.io_read = 1'b0;
        check("mid_rst_an",    {24'h0, seg_an},  32'hFF);
        check("mid_rst_seg",   {24'h0, seg_out}, 32'hFF);
        check("mid_rst_rdata", bus.rdata,        32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_an",  {24'h0, seg_an},  32'hFE);
        check("post_rst_seg", {24'h0, seg_out}, 32'hC0);
        bus_read(4'h0);
        check("post_rst_data", bus.rdata, 32'h0);
        bus_read(4'h4);
        check("post_rst_ctrl", bus.rdata, 32'h0000_00FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
